fetch_unit_rv32i: RTL and testbench
===================================

FETCH_UNIT_RV32I -- requirements
Module: fetch_unit_rv32i

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port PCin  input  32  next-PC selected by the brancher (PC+4 or PC+imm), sampled at instruction acceptance.
REQ-005 The block SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 The block SHALL have port imem_addr  output  32  fetch address; equals PC.
REQ-007 The block SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 The block SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 The block SHALL have port PC  output  32  address of the current instruction.
REQ-011 The block SHALL have port PCnew  output  32  PC+4, fed to the brancher.
REQ-012 The block SHALL have port instr  output  32  held instruction word.
REQ-013 The block SHALL have port instr_valid  output  1  instr is valid for the decode stage.
REQ-014 The block SHALL have port instr_ready  input  1  decode stage accepts instr.
REQ-015 The block SHALL have port fault  output  1  sticky misaligned-target flag.
REQ-016 The block SHALL have port fetch_count  output  32  number of accepted instructions.

Function
REQ-017 The FSM SHALL have states REQ, WAIT, OUT, FAULT.
REQ-018 In REQ, imem_req SHALL be 1; on imem_gnt=1 the FSM SHALL go to WAIT.
REQ-019 In WAIT, imem_req SHALL be 0; on imem_rvalid=1, instr SHALL be loaded with imem_rdata and the FSM SHALL go to OUT.
REQ-020 imem_rvalid SHALL be ignored in all states except WAIT; memory returns data at least one cycle after gnt.
REQ-021 In OUT, instr_valid SHALL be 1 and instr SHALL stay stable until instr_ready=1.
REQ-022 On instr_valid & instr_ready with PCin[1:0]==2'b00: PC SHALL load PCin, fetch_count SHALL increment by 1, and the FSM SHALL go to REQ in the next cycle.
REQ-023 On instr_valid & instr_ready with PCin[1:0]!=2'b00: PC SHALL hold, fetch_count SHALL increment, the FSM SHALL go to FAULT, and fault SHALL be 1 from the next cycle.
REQ-024 FAULT SHALL be absorbing: imem_req=0, instr_valid=0, fault=1 until reset.
REQ-025 PCnew SHALL be PC+4 computed modulo 2^32, so 32'hFFFF_FFFC gives 32'h0000_0000.
REQ-026 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 Only one request SHALL be outstanding at a time; latency from the REQ grant to instr_valid SHALL be the memory latency plus one cycle.

Reset
REQ-028 On reset: state=REQ, PC=RESET_PC, instr=0, instr_valid=0, fault=0, fetch_count=0, imem_req=1 in the first cycle after reset.
REQ-029 Reset in WAIT or OUT SHALL abandon the transaction; an imem_rvalid arriving after reset SHALL be ignored because the state is REQ.

Structure
REQ-030 State encoding (2-bit) and the default RESET_PC constant SHALL live in the shared package rv32i_pkg.
REQ-031 PC+4 SHALL be a single sub-module pc_incr_rv32i (32-bit add-4, purely combinational).

Verification
REQ-032 Reset, gnt immediately, rvalid one cycle later with rdata=32'h0000_0013, instr_ready=1 -> imem_addr=0, instr=32'h0000_0013, instr_valid for 1 cycle, fetch_count=1.
REQ-033 Accept with PCin=32'h0000_0040 (taken branch) -> next imem_addr=32'h0000_0040, PCnew=32'h0000_0044.
REQ-034 Hold instr_ready=0 for 5 cycles in OUT -> instr and PC stable, imem_req=0, fetch_count unchanged.
REQ-035 Accept with PCin=32'h0000_0042 -> fault=1, imem_req=0 permanently, PC unchanged; reset clears fault and restarts at RESET_PC.
REQ-036 Assert reset during WAIT, then pulse rvalid with rdata=32'hDEAD_BEEF -> rdata ignored, instr_valid=0, new request issued at RESET_PC.
REQ-037 Set PC=32'hFFFF_FFFC -> PCnew=32'h0000_0000, and accepting with PCin=PCnew fetches address 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch FSM encoding and default reset PC
package rv32i_pkg;
    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_incr_rv32i.sv
// pc_incr_rv32i: combinational PC+4, wrapping modulo 2^32
module pc_incr_rv32i (
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);
    assign pc_next = pc + 32'd4;
endmodule

// File: rtl/fetch_unit_rv32i.sv
// fetch_unit_rv32i: single-outstanding instruction fetch with misaligned-target fault
module fetch_unit_rv32i
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PCin,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCnew,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fault,
    output logic [31:0] fetch_count
);
    logic [1:0] state;

    pc_incr_rv32i u_incr (
        .pc      (PC),
        .pc_next (PCnew)
    );

    assign imem_req    = state == S_REQ;
    assign imem_addr   = PC;
    assign instr_valid = state == S_OUT;
    assign fault       = state == S_FAULT;

    // request -> wait for data -> hold for decode; a misaligned next PC parks the unit in FAULT
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_REQ;
            PC          <= RESET_PC;
            instr       <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                S_REQ: state <= imem_gnt ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (instr_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        if (PCin[1:0] == 2'b00) begin
                            PC    <= PCin;
                            state <= S_REQ;
                        end else begin
                            state <= S_FAULT;
                        end
                    end
                end
                default: state <= S_FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// tb_fetch_unit_rv32i: directed self-checking bench for the fetch unit
module tb_fetch_unit_rv32i;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] PCin;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] PCnew;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fault;
    logic [31:0] fetch_count;
    int checks = 0;
    int errors = 0;

    fetch_unit_rv32i dut (
        .clock       (clock),
        .reset       (reset),
        .PCin        (PCin),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .PCnew       (PCnew),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch_to_out(input logic [31:0] addr, input logic [31:0] data);
        chk("req_high", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        @(negedge clock);
        imem_gnt = 1'b0;
        chk("wait_req_low", {31'd0, imem_req}, 32'd0);
        chk("wait_not_valid", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clock);
        imem_rvalid = 1'b0;
        chk("out_valid", {31'd0, instr_valid}, 32'd1);
        chk("out_instr", instr, data);
    endtask

    task automatic accept(input logic [31:0] next_pc);
        instr_ready = 1'b1;
        PCin        = next_pc;
        @(negedge clock);
        instr_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; PCin = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; instr_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_pcnew", PCnew, 32'h4);

        fetch_to_out(32'h0, 32'h0000_0013);
        accept(32'h4);
        chk("acc1_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("acc1_count", fetch_count, 32'd1);
        chk("acc1_pc", PC, 32'h4);

        fetch_to_out(32'h4, 32'h0000_0093);
        accept(32'h40);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_pcnew", PCnew, 32'h44);
        chk("br_count", fetch_count, 32'd2);

        fetch_to_out(32'h40, 32'h00A0_0113);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_instr", instr, 32'h00A0_0113);
            chk("stall_pc", PC, 32'h40);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_count", fetch_count, 32'd2);
        end

        accept(32'h42);
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_pc", PC, 32'h40);
        chk("mis_count", fetch_count, 32'd3);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; instr_ready = 1'b1; PCin = 32'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("fault_sticky", {31'd0, fault}, 32'd1);
            chk("fault_req", {31'd0, imem_req}, 32'd0);
            chk("fault_valid", {31'd0, instr_valid}, 32'd0);
            chk("fault_pc", PC, 32'h40);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("clr_fault", {31'd0, fault}, 32'd0);
        chk("clr_pc", PC, 32'h0);
        chk("clr_req", {31'd0, imem_req}, 32'd1);
        chk("clr_count", fetch_count, 32'd0);

        imem_gnt = 1'b1;
        @(negedge clock);
        imem_gnt = 1'b0;
        chk("wrst_in_wait", {31'd0, imem_req}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_rvalid = 1'b0;
        chk("wrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("wrst_instr", instr, 32'h0);
        chk("wrst_req", {31'd0, imem_req}, 32'd1);
        chk("wrst_addr", imem_addr, 32'h0);

        fetch_to_out(32'h0, 32'h0000_0013);
        accept(32'hFFFF_FFFC);
        chk("top_pc", PC, 32'hFFFF_FFFC);
        chk("top_pcnew", PCnew, 32'h0);
        fetch_to_out(32'hFFFF_FFFC, 32'h0000_006F);
        accept(32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_count", fetch_count, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
